// File: rtl/ibm_1620_timing_ring_pkg.sv
// ---------------------------------------------------------------------------
// ibm_1620_timing_pkg
// Shared constants for the IBM 1620 memory-cycle timing ring:
//   - FSM state encoding (legacy two-bit codes)
//   - default ring geometry and oscillator-loss timeout
// ---------------------------------------------------------------------------
package ibm_1620_timing_pkg;

    // Ring control states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;
    localparam logic [1:0] ST_SINGLE   = 2'd3;

    // Default geometry: 10 positions x 2 pulses x 1 us = 20 us memory cycle
    localparam int DEF_POSITIONS      = 10;
    localparam int DEF_PULSES_PER_POS = 2;
    localparam int DEF_OSC_TIMEOUT    = 16;

endpackage

// File: rtl/ibm_1620_timing_ring_if.sv
// ---------------------------------------------------------------------------
// ibm_1620_timing_ring_if
// Bundle between the CPU control side (master) and the timing ring (slave).
//   osc_pulse   : oscillator strobe, one clk wide
//   run_req     : level, run continuously
//   single_req  : level, rising edge requests one memory cycle
//   fail_clr    : strobe, clears the sticky oscillator-loss flag
//   timing_gate : one-hot ring position T0..T(POSITIONS-1)
//   cycle_end   : one-clk pulse on the wrap back to T0
//   running     : ring control is not idle
//   osc_fail    : sticky oscillator-loss flag
// ---------------------------------------------------------------------------
interface ibm_1620_timing_ring_if
    import ibm_1620_timing_pkg::*;
#(
    parameter int POSITIONS = DEF_POSITIONS
);
    logic                 osc_pulse;
    logic                 run_req;
    logic                 single_req;
    logic                 fail_clr;
    logic [POSITIONS-1:0] timing_gate;
    logic                 cycle_end;
    logic                 running;
    logic                 osc_fail;

    modport master (
        output osc_pulse, run_req, single_req, fail_clr,
        input  timing_gate, cycle_end, running, osc_fail
    );

    modport slave (
        input  osc_pulse, run_req, single_req, fail_clr,
        output timing_gate, cycle_end, running, osc_fail
    );
endinterface

// File: rtl/ibm_1620_osc_watchdog.sv
// ---------------------------------------------------------------------------
// ibm_1620_osc_watchdog
// Counts clk cycles since the last osc_pulse, saturating at OSC_TIMEOUT.
//   clk, rst_n : clock, asynchronous active-low reset
//   osc_pulse  : oscillator strobe; clears the count
//   fail_clr   : clears osc_fail (re-sets next cycle if still timed out)
//   osc_fail   : sticky oscillator-loss flag
//   trip       : the count reaches/holds OSC_TIMEOUT on this edge; lets the
//                ring abort on the same edge that osc_fail sets
// ---------------------------------------------------------------------------
module ibm_1620_osc_watchdog
    import ibm_1620_timing_pkg::*;
#(
    parameter int OSC_TIMEOUT = DEF_OSC_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_pulse,
    input  logic fail_clr,
    output logic osc_fail,
    output logic trip
);
    localparam int CNT_W = $clog2(OSC_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // The edge that would move the count to OSC_TIMEOUT (or keep it there)
    assign trip = !osc_pulse && (count >= CNT_W'(OSC_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            osc_fail <= 1'b0;
        end else begin
            if (osc_pulse)
                count <= '0;
            else if (count != CNT_W'(OSC_TIMEOUT))
                count <= count + 1'b1;

            // Clear wins for one cycle; a still-saturated count re-trips next edge
            if (fail_clr)
                osc_fail <= 1'b0;
            else if (trip)
                osc_fail <= 1'b1;
        end
    end
endmodule

// File: rtl/ibm_1620_timing_ring.sv
// ---------------------------------------------------------------------------
// ibm_1620_timing_ring
// Turns oscillator pulses into one-hot memory-cycle timing gates T0..T9 with
// run / single-cycle / stop-at-cycle-end control and an oscillator watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ibm_1620_timing_ring_if.slave (see interface header)
// The interface POSITIONS parameter must match this module's POSITIONS.
// ---------------------------------------------------------------------------
module ibm_1620_timing_ring
    import ibm_1620_timing_pkg::*;
#(
    parameter int POSITIONS      = DEF_POSITIONS,
    parameter int PULSES_PER_POS = DEF_PULSES_PER_POS,
    parameter int OSC_TIMEOUT    = DEF_OSC_TIMEOUT
) (
    input logic                    clk,
    input logic                    rst_n,
    ibm_1620_timing_ring_if.slave  bus
);
    localparam int SUB_W = (PULSES_PER_POS > 1) ? $clog2(PULSES_PER_POS) : 1;

    logic [1:0]           state, state_nx;
    logic [POSITIONS-1:0] gate;
    logic [SUB_W-1:0]     sub;
    logic                 cycle_end;
    logic                 single_q;
    logic                 osc_fail;
    logic                 trip;

    logic single_rise, advance, term, wrap;

    ibm_1620_osc_watchdog #(
        .OSC_TIMEOUT (OSC_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .osc_pulse (bus.osc_pulse),
        .fail_clr  (bus.fail_clr),
        .osc_fail  (osc_fail),
        .trip      (trip)
    );

    assign single_rise = bus.single_req && !single_q;
    // The ring is parked in IDLE, so a newly entered state first advances
    // on the following edge
    assign advance     = (state != ST_IDLE) && bus.osc_pulse;
    assign term        = (sub == SUB_W'(PULSES_PER_POS - 1));
    assign wrap        = advance && term && gate[POSITIONS-1];

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                // RUN has priority; a simultaneous single edge is dropped
                if (!osc_fail) begin
                    if (bus.run_req)
                        state_nx = ST_RUN;
                    else if (single_rise)
                        state_nx = ST_SINGLE;
                end
            end
            ST_RUN: begin
                // Dropping run_req exactly on the wrap edge stops there
                if (!bus.run_req)
                    state_nx = wrap ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (bus.run_req)
                    state_nx = ST_RUN;
                else if (wrap)
                    state_nx = ST_IDLE;
            end
            ST_SINGLE: begin
                if (wrap)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gate      <= POSITIONS'(1);
            sub       <= '0;
            cycle_end <= 1'b0;
            single_q  <= 1'b0;
        end else begin
            single_q <= bus.single_req;
            if (trip) begin
                // Oscillator loss: abandon the cycle without a cycle_end
                state     <= ST_IDLE;
                gate      <= POSITIONS'(1);
                sub       <= '0;
                cycle_end <= 1'b0;
            end else begin
                state     <= state_nx;
                cycle_end <= wrap;
                if (advance) begin
                    if (term) begin
                        sub  <= '0;
                        gate <= {gate[POSITIONS-2:0], gate[POSITIONS-1]};
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.timing_gate = gate;
    assign bus.cycle_end   = cycle_end;
    assign bus.running     = (state != ST_IDLE);
    assign bus.osc_fail    = osc_fail;
endmodule
